// File: rtl/probe_link_hub.sv
// Host-side end of the serial probe link: down-link command strobe, up-link word
// capture with one-deep hold for burst-end tagging, and an output FIFO.
module probe_link_hub #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CMD_GAP    = 0
) (
  input  logic        UCLK,
  input  logic        URST,
  input  logic        HCMD_VALID,
  input  logic [18:0] HCMD,
  output logic        HCMD_READY,
  output logic        CMDEN,
  output logic [18:0] CMD,
  input  logic [31:0] DATAUP,
  input  logic        DATAVALID,
  output logic        ACK,
  input  logic        DELAY,
  output logic        OUT_VALID,
  output logic [33:0] OUT_DATA,
  input  logic        OUT_READY,
  output logic        BUSY,
  output logic [15:0] BURSTCNT,
  output logic [7:0]  ERRCNT
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [7:0] GapLoad = 8'(CMD_GAP);

  // Down link
  logic [7:0]  gap_q, gap_d;
  logic        cmden_q;
  logic [18:0] cmd_q;
  logic        cmd_accept;

  assign HCMD_READY = URST && (gap_q == 8'd0);
  assign cmd_accept = HCMD_VALID && HCMD_READY;
  assign CMDEN      = cmden_q;
  assign CMD        = cmd_q;

  // gap counts the idle cycles that must follow each CMDEN pulse
  always_comb begin
    gap_d = gap_q;
    if (cmd_accept) begin
      gap_d = GapLoad;
    end else if (gap_q != 8'd0) begin
      gap_d = gap_q - 8'd1;
    end
  end

  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      gap_q   <= 8'd0;
      cmden_q <= 1'b0;
      cmd_q   <= 19'd0;
    end else begin
      gap_q   <= gap_d;
      cmden_q <= cmd_accept;
      if (cmd_accept) begin
        cmd_q <= HCMD;
      end
    end
  end

  // Up link
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_word_q;
  logic        hold_err_q;
  logic        word_err;
  logic [12:0] word_pad;
  logic [2:0]  word_code;

  logic [33:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_full;
  logic            push, push_last, pop;
  logic [33:0]     push_entry;

  logic [15:0] burst_q;
  logic [7:0]  err_q;

  assign word_pad  = DATAUP[15:3];
  assign word_code = DATAUP[2:0];
  assign word_err  = (word_pad != 13'h1FFF) || (word_code == 3'd0) || (word_code > 3'd3);

  assign fifo_full = (count_q == FullCnt);
  assign OUT_VALID = (count_q != '0);
  assign OUT_DATA  = fifo_q[rd_ptr_q];
  assign pop       = OUT_VALID && OUT_READY;

  // Registered count only: a pop in the same cycle does not open a slot for ACK
  assign ACK = URST && DATAVALID && (!hold_valid_q || !fifo_full);

  always_comb begin
    push         = 1'b0;
    push_last    = 1'b0;
    hold_valid_d = hold_valid_q;
    if (ACK) begin
      push         = hold_valid_q;
      hold_valid_d = 1'b1;
    end else if (!DATAVALID && hold_valid_q && (!fifo_full || pop)) begin
      // Source went idle: the held word closes the burst
      push         = 1'b1;
      push_last    = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  assign push_entry = {hold_err_q, push_last, hold_word_q};

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= 32'd0;
      hold_err_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      burst_q      <= 16'd0;
      err_q        <= 8'd0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 34'd0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      if (ACK) begin
        hold_word_q <= DATAUP;
        hold_err_q  <= word_err;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      if (push && push_last) begin
        burst_q <= burst_q + 16'd1;
      end
      if (push && hold_err_q && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign BUSY     = DELAY || hold_valid_q || OUT_VALID;
  assign BURSTCNT = burst_q;
  assign ERRCNT   = err_q;

endmodule

// File: tb/tb_probe_link_hub.sv
// Directed bench for probe_link_hub: command strobe timing, burst tagging through
// a scoreboard queue, counters and asynchronous reset.
module tb_probe_link_hub;

  logic        UCLK;
  logic        URST;
  logic        hv0, hv3;
  logic [18:0] hc0, hc3;
  logic        rdy0, rdy3, cmden0, cmden3;
  logic [18:0] cmd0, cmd3;
  logic [31:0] DATAUP;
  logic        DATAVALID, ACK, DELAY, OUT_VALID, OUT_READY, BUSY;
  logic [33:0] OUT_DATA;
  logic [15:0] BURSTCNT;
  logic [7:0]  ERRCNT;
  logic        g3_ack, g3_ov, g3_busy;
  logic [33:0] g3_od;
  logic [15:0] g3_bc;
  logic [7:0]  g3_ec;

  probe_link_hub #(.FIFO_DEPTH(4), .CMD_GAP(0)) u_g0 (
    .UCLK(UCLK), .URST(URST), .HCMD_VALID(hv0), .HCMD(hc0), .HCMD_READY(rdy0),
    .CMDEN(cmden0), .CMD(cmd0), .DATAUP(DATAUP), .DATAVALID(DATAVALID), .ACK(ACK),
    .DELAY(DELAY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .BURSTCNT(BURSTCNT), .ERRCNT(ERRCNT)
  );

  probe_link_hub #(.FIFO_DEPTH(4), .CMD_GAP(3)) u_g3 (
    .UCLK(UCLK), .URST(URST), .HCMD_VALID(hv3), .HCMD(hc3), .HCMD_READY(rdy3),
    .CMDEN(cmden3), .CMD(cmd3), .DATAUP(32'd0), .DATAVALID(1'b0), .ACK(g3_ack),
    .DELAY(1'b0), .OUT_VALID(g3_ov), .OUT_DATA(g3_od), .OUT_READY(1'b0),
    .BUSY(g3_busy), .BURSTCNT(g3_bc), .ERRCNT(g3_ec)
  );

  initial UCLK = 1'b0;
  always #5 UCLK = ~UCLK;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q [$];
  logic        s_ack, s_rdy0, s_cmden0, s_rdy3, s_cmden3;
  logic [18:0] s_cmd0, s_cmd3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] w);
    logic [2:0] c;
    c = w[2:0];
    return (w[15:3] != 13'h1FFF) || !(c inside {3'd1, 3'd2, 3'd3});
  endfunction

  // One clock cycle: sample at the falling edge, return just after the rising edge
  task automatic step();
    logic [33:0] e;
    @(negedge UCLK);
    s_ack    = ACK;
    s_rdy0   = rdy0;
    s_cmden0 = cmden0;
    s_cmd0   = cmd0;
    s_rdy3   = rdy3;
    s_cmden3 = cmden3;
    s_cmd3   = cmd3;
    if (OUT_VALID && OUT_READY) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_out_data", 64'(OUT_DATA), 64'(e));
      end
    end
    @(posedge UCLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input bit last, input int budget, output bit ok);
    ok        = 1'b0;
    DATAVALID = 1'b1;
    DATAUP    = w;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (s_ack) begin
        ok = 1'b1;
        exp_q.push_back({model_err(w), last, w});
      end
    end
  endtask

  task automatic drain(input int n);
    DATAVALID = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    bit ok;
    int accepts, pulses, p0, p1;
    logic rdy_after;
    logic [31:0] w;

    URST = 1'b0; hv0 = 1'b0; hv3 = 1'b0; hc0 = '0; hc3 = '0;
    DATAUP = 32'h0005FFFB; DATAVALID = 1'b1; DELAY = 1'b0; OUT_READY = 1'b0;
    p0 = 0; p1 = 0;
    #3;
    check("rst_ack", 64'(ACK), 64'd0);
    check("rst_ready0", 64'(rdy0), 64'd0);
    check("rst_ready3", 64'(rdy3), 64'd0);
    check("rst_cmden", 64'(cmden0), 64'd0);
    check("rst_cmd", 64'(cmd0), 64'd0);
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_burstcnt", 64'(BURSTCNT), 64'd0);
    check("rst_errcnt", 64'(ERRCNT), 64'd0);
    DATAVALID = 1'b0;
    #9 URST = 1'b1;
    @(posedge UCLK); #1;

    // Back-to-back commands with no gap
    hv0 = 1'b1; hc0 = 19'h0002A;
    step();
    check("t1_ready_a", 64'(s_rdy0), 64'd1);
    hc0 = 19'h00015;
    step();
    check("t1_cmden_a", 64'(s_cmden0), 64'd1);
    check("t1_cmd_a", 64'(s_cmd0), 64'h0002A);
    check("t1_ready_b", 64'(s_rdy0), 64'd1);
    hv0 = 1'b0;
    step();
    check("t1_cmden_b", 64'(s_cmden0), 64'd1);
    check("t1_cmd_b", 64'(s_cmd0), 64'h00015);
    step();
    check("t1_cmden_off", 64'(s_cmden0), 64'd0);
    check("t1_cmd_hold", 64'(s_cmd0), 64'h00015);

    // Gap of 3 idle cycles between strobes
    hv3 = 1'b1; hc3 = 19'h00101; accepts = 0; pulses = 0; rdy_after = 1'bx;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c == 1) rdy_after = s_rdy3;
      if (s_cmden3) begin
        if (pulses == 0) p0 = c; else p1 = c;
        pulses++;
      end
      if (hv3 && s_rdy3) begin
        accepts++;
        hc3 = 19'h00202;
        if (accepts == 2) hv3 = 1'b0;
      end
    end
    check("t2_pulses", 64'(pulses), 64'd2);
    check("t2_spacing", 64'(p1 - p0), 64'd4);
    check("t2_ready_blocked", 64'(rdy_after), 64'd0);
    check("t2_cmd_last", 64'(s_cmd3), 64'h00202);

    // Short good burst, free-flowing output
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 32'h0005FFFB + 32'(i) * 32'h00020000;
      offer(w, i == 2, 1, ok);
      check("t3_ack", 64'(ok), 64'd1);
    end
    drain(6);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t3_burstcnt", 64'(BURSTCNT), 64'd1);
    check("t3_errcnt", 64'(ERRCNT), 64'd0);

    // Back-pressure: 4 in FIFO + 1 held, then ACK stalls
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 32'h0010FFF9 + 32'(i) * 32'h00010000;
      offer(w, 1'b0, 1, ok);
      check("t4_ack", 64'(ok), 64'd1);
    end
    offer(32'h0015FFFA, 1'b1, 3, ok);
    check("t4_ack_stall", 64'(ok), 64'd0);
    check("t4_out_valid", 64'(OUT_VALID), 64'd1);
    check("t4_busy", 64'(BUSY), 64'd1);
    OUT_READY = 1'b1;
    offer(32'h0015FFFA, 1'b1, 4, ok);
    check("t4_ack_resume", 64'(ok), 64'd1);
    drain(10);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t4_burstcnt", 64'(BURSTCNT), 64'd2);
    check("t4_out_idle", 64'(OUT_VALID), 64'd0);

    // Malformed words and error-count saturation
    offer(32'h00051234, 1'b1, 2, ok);
    check("t5_ack", 64'(ok), 64'd1);
    drain(4);
    check("t5_errcnt_one", 64'(ERRCNT), 64'd1);
    check("t5_burstcnt", 64'(BURSTCNT), 64'd3);
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       w = {16'(i), 16'h1234};
        1:       w = {16'(i), 16'hFFF8};
        default: w = {16'(i), 16'hFFFD};
      endcase
      offer(w, i == 299, 3, ok);
      if (!ok) check("t5_bulk_ack", 64'(ok), 64'd1);
    end
    drain(6);
    check("t5_errcnt_sat", 64'(ERRCNT), 64'hFF);
    check("t5_burstcnt_b", 64'(BURSTCNT), 64'd4);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    DELAY = 1'b1;
    #1 check("busy_delay", 64'(BUSY), 64'd1);
    DELAY = 1'b0;
    #1 check("busy_idle", 64'(BUSY), 64'd0);

    // Asynchronous reset in the middle of a burst
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h0020FFFB + 32'(i) * 32'h00010000, 1'b0, 1, ok);
      check("t6_ack", 64'(ok), 64'd1);
    end
    check("t6_busy_pre", 64'(BUSY), 64'd1);
    URST = 1'b0;
    #1;
    check("t6_ack_rst", 64'(ACK), 64'd0);
    check("t6_out_valid_rst", 64'(OUT_VALID), 64'd0);
    check("t6_burstcnt_rst", 64'(BURSTCNT), 64'd0);
    check("t6_errcnt_rst", 64'(ERRCNT), 64'd0);
    check("t6_busy_rst", 64'(BUSY), 64'd0);
    exp_q.delete();
    step();
    URST = 1'b1;
    drain(4);
    check("t6_out_valid_post", 64'(OUT_VALID), 64'd0);
    check("t6_burstcnt_post", 64'(BURSTCNT), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
